// File: rtl/tron_pkg.sv
// Shared types and geometry for the frame-buffer writer.
//   dir_t       : bike heading, 00 up, 01 down, 10 left, 11 right
//   wr_state_t  : writer FSM states
//   off_x/off_y : trail-cell offset from the bike position, per heading
//   cell_ox/oy  : word-aligned cell origin in signed 11-bit pixel space
package tron_pkg;

   localparam int unsigned FB_W     = 640;
   localparam int unsigned FB_H     = 480;
   localparam int unsigned FB_WORDS = 153600;

   typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_t;

   typedef enum logic [2:0] {CLEAR, IDLE, LATCH, BLUE, RED} wr_state_t;

   // Offsets place the cell behind the bike, i.e. at its tail.
   function automatic logic signed [10:0] off_x(input dir_t d, input int unsigned ts);
      int v;
      case (d)
         UP, DOWN: v = -2;
         LEFT:     v = 32;
         default:  v = -4 - int'(ts);
      endcase
      return 11'(v);
   endfunction

   function automatic logic signed [10:0] off_y(input dir_t d, input int unsigned ts);
      int v;
      case (d)
         UP:      v = 16;
         DOWN:    v = -4 - int'(ts);
         default: v = -2;
      endcase
      return 11'(v);
   endfunction

   // Clearing bit 0 aligns the cell to a two-pixel word.
   function automatic logic signed [10:0] cell_ox(input logic [9:0] x, input dir_t d,
                                                  input int unsigned ts);
      logic signed [10:0] sum;
      sum = $signed({1'b0, x}) + off_x(d, ts);
      return sum & ~11'sd1;
   endfunction

   function automatic logic signed [10:0] cell_oy(input logic [9:0] y, input dir_t d,
                                                  input int unsigned ts);
      return $signed({1'b0, y}) + off_y(d, ts);
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Pixel-to-word address mapping for the 640x480 frame buffer.
//   px, py    : signed 11-bit pixel coordinates (may lie off screen)
//   in_bounds : 1 when 0 <= px < 640 and 0 <= py < 480
//   addr      : word address px/2 + py*320 (meaningful only when in_bounds)
module fb_addr_gen (
   input  logic signed [10:0] px,
   input  logic signed [10:0] py,
   output logic               in_bounds,
   output logic [18:0]        addr
);
   logic [18:0] px_w;
   logic [18:0] py_w;

   always_comb begin
      in_bounds = !px[10] && (px[9:0] < 10'd640) && !py[10] && (py[9:0] < 10'd480);
      px_w      = {9'd0, px[9:0]};
      py_w      = {9'd0, py[9:0]};
      // py*320 as two shifts
      addr      = (px_w >> 1) + (py_w << 8) + (py_w << 6);
   end

endmodule

// File: rtl/trail_frame_writer.sv
// Write side of the 640x480 4-bit-colour frame buffer.
// Clears the buffer after reset or clear_req, then on each frame_clk rise stamps a
// TRAIL_SZ x TRAIL_SZ cell behind each live bike (blue first, then red).
//   Clk, Reset (sync, active low), frame_clk (async ~60 Hz), clear_req (pulse)
//   blue_alive/red_alive, Blue/Red_X_real, Blue/Red_Y_real, Blue/Red_dir : bike state
//   Data_In, write_address, WE : registered frameRAM write port, one word per cycle
//   busy : FSM not idle;  clear_done : pulse with the last clear write
module trail_frame_writer
   import tron_pkg::*;
#(
   parameter int unsigned TRAIL_SZ   = 4,
   parameter logic [3:0]  BG_COLOR   = 4'h0,
   parameter logic [3:0]  BLUE_TRAIL = 4'h4,
   parameter logic [3:0]  RED_TRAIL  = 4'h6
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        clear_req,
   input  logic        blue_alive,
   input  logic        red_alive,
   input  logic [9:0]  Blue_X_real,
   input  logic [9:0]  Blue_Y_real,
   input  logic [9:0]  Red_X_real,
   input  logic [9:0]  Red_Y_real,
   input  logic [1:0]  Blue_dir,
   input  logic [1:0]  Red_dir,
   output logic [15:0] Data_In,
   output logic [18:0] write_address,
   output logic        WE,
   output logic        busy,
   output logic        clear_done
);
   localparam int unsigned RowW = $clog2(TRAIL_SZ);
   localparam int unsigned ColW = (TRAIL_SZ > 2) ? $clog2(TRAIL_SZ / 2) : 1;
   localparam int unsigned ClrW = $clog2(FB_WORDS);
   localparam logic [RowW-1:0] RowLast = RowW'(TRAIL_SZ - 1);
   localparam logic [ColW-1:0] ColLast = ColW'(TRAIL_SZ / 2 - 1);
   localparam logic [ClrW-1:0] ClrLast = ClrW'(FB_WORDS - 1);

   wr_state_t          state_q, state_d;
   logic               fc_s1_q, fc_s2_q, fc_s3_q;
   logic               frame_edge;
   logic               pending_q, pending_d;
   logic [ClrW-1:0]    clr_q, clr_d;
   logic [RowW-1:0]    row_q, row_d;
   logic [ColW-1:0]    col_q, col_d;
   logic signed [10:0] box_q, boy_q, rox_q, roy_q;
   logic               ralive_q;

   logic signed [10:0] px, py;
   logic               pix_ok;
   logic [18:0]        pix_addr;

   logic               wr_en, done_d;
   logic [18:0]        wr_addr;
   logic [3:0]         wr_col;

   logic [15:0]        data_q;
   logic [18:0]        addr_q;
   logic               we_q, done_q;

   assign frame_edge = fc_s2_q & ~fc_s3_q;

   always_comb begin
      px = ((state_q == RED) ? rox_q : box_q) + $signed({{(10 - ColW){1'b0}}, col_q, 1'b0});
      py = ((state_q == RED) ? roy_q : boy_q) + $signed({{(11 - RowW){1'b0}}, row_q});
   end

   fb_addr_gen u_addr (
      .px        (px),
      .py        (py),
      .in_bounds (pix_ok),
      .addr      (pix_addr)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      clr_d     = clr_q;
      row_d     = row_q;
      col_d     = col_q;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_col    = BG_COLOR;
      done_d    = 1'b0;
      case (state_q)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = 19'(clr_q);
            if (clr_q == ClrLast) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               clr_d = clr_q + 1'b1;
            end
         end
         IDLE: begin
            if (frame_edge || pending_q) begin
               state_d   = LATCH;
               pending_d = 1'b0;
            end
         end
         LATCH: begin
            if (frame_edge) pending_d = 1'b1;
            row_d = '0;
            col_d = '0;
            // A dead bike's pass takes no cycles at all.
            if (blue_alive)     state_d = BLUE;
            else if (red_alive) state_d = RED;
            else                state_d = IDLE;
         end
         BLUE, RED: begin
            if (frame_edge) pending_d = 1'b1;
            // Off-screen words still use their slot so the pass length is fixed.
            wr_en   = pix_ok;
            wr_addr = pix_addr;
            wr_col  = (state_q == BLUE) ? BLUE_TRAIL : RED_TRAIL;
            if (col_q == ColLast) begin
               col_d = '0;
               if (row_q == RowLast) begin
                  row_d   = '0;
                  state_d = (state_q == BLUE && ralive_q) ? RED : IDLE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase
      // clear_req overrides everything: word 0 is written this cycle, sweep resumes at 1.
      if (clear_req) begin
         state_d   = CLEAR;
         pending_d = 1'b0;
         clr_d     = ClrW'(1);
         wr_en     = 1'b1;
         wr_addr   = '0;
         wr_col    = BG_COLOR;
         done_d    = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= CLEAR;
         fc_s1_q   <= 1'b0;
         fc_s2_q   <= 1'b0;
         fc_s3_q   <= 1'b0;
         pending_q <= 1'b0;
         clr_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         box_q     <= '0;
         boy_q     <= '0;
         rox_q     <= '0;
         roy_q     <= '0;
         ralive_q  <= 1'b0;
         data_q    <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         fc_s1_q   <= frame_clk;
         fc_s2_q   <= fc_s1_q;
         fc_s3_q   <= fc_s2_q;
         pending_q <= pending_d;
         clr_q     <= clr_d;
         row_q     <= row_d;
         col_q     <= col_d;
         if (state_q == LATCH) begin
            box_q    <= cell_ox(Blue_X_real, dir_t'(Blue_dir), TRAIL_SZ);
            boy_q    <= cell_oy(Blue_Y_real, dir_t'(Blue_dir), TRAIL_SZ);
            rox_q    <= cell_ox(Red_X_real, dir_t'(Red_dir), TRAIL_SZ);
            roy_q    <= cell_oy(Red_Y_real, dir_t'(Red_dir), TRAIL_SZ);
            ralive_q <= red_alive;
         end
         data_q    <= {4'h0, wr_col, 4'h0, wr_col};
         addr_q    <= wr_addr;
         we_q      <= wr_en;
         done_q    <= done_d;
      end
   end

   assign Data_In       = data_q;
   assign write_address = addr_q;
   assign WE            = we_q;
   assign clear_done    = done_q;
   assign busy          = (state_q != IDLE);

endmodule
